lut_table_loader: RTL and testbench
===================================

// Module: lut_table_loader
// PURPOSE
//  Runtime writer for a LogicNets neuron truth table. It accepts a packed truth-table stream
//  over a valid/ready config port and unpacks it, one entry per cycle, into a distributed-RAM LUT.
//  It then serves registered lookups (input code -> neuron output) to the inference fabric.
//  It replaces a fixed case-ROM neuron where weights must be reloaded without resynthesis.
// PARAMETERS
//  IN_BITS   8   neuron input code width; DEPTH = 2**IN_BITS entries
//  OUT_BITS  1   neuron output width (bits per entry)
//  WORD_W    32  config word width; multiple of OUT_BITS, divides DEPTH*OUT_BITS
// PORTS
//  clk        in   1            single clock, all logic rising-edge
//  rst        in   1            synchronous, active-high reset
//  load_start in   1            1-cycle pulse: begin (re)load, invalidates table
//  cfg_valid  in   1            config word valid
//  cfg_ready  out  1            loader can accept a config word
//  cfg_data   in   WORD_W       packed entries
//  cfg_last   in   1            marks final word of table
//  busy       out  1            high in LOAD/WRITE
//  done       out  1            1-cycle pulse: table fully and correctly loaded
//  err        out  1            1-cycle pulse: length mismatch, table invalid
//  table_vld  out  1            table valid, lookups served
//  lk_valid   in   1            lookup request
//  lk_addr    in   IN_BITS      neuron input code
//  rd_valid   out  1            lookup result valid (lk_valid delayed 1 cycle, if served)
//  rd_data    out  OUT_BITS     neuron output for lk_addr
// BEHAVIOUR
//  - Reset: state IDLE; cfg_ready, busy, done, err, table_vld, rd_valid, rd_data all 0; counters 0.
//    RAM contents are not reset; table_vld=0 masks them.
//  - Packing: EPW = WORD_W/OUT_BITS entries per word; NW = DEPTH/EPW words. Word k, slice j
//    (bits j*OUT_BITS +: OUT_BITS) is the entry for address k*EPW+j, where the address is lk_addr as unsigned.
//  - FSM: IDLE -> LOAD on load_start. LOAD: cfg_ready=1; on cfg_valid&cfg_ready, latch the word
//    into the shift register and go to WRITE. WRITE: cfg_ready=0; write one entry per cycle for
//    EPW cycles, address = word_cnt*EPW+slice. After the final slice:
//      * word_cnt==NW-1 and latched last=1 -> READY, done=1, table_vld=1.
//      * word_cnt <NW-1 and last=0 -> word_cnt++, back to LOAD.
//      * any other combination (last early, or missing on word NW-1) -> IDLE, err=1, table_vld=0.
//  - Throughput: EPW+1 cycles per word. Default full load = 8*33 = 264 cycles from the first handshake.
//  - READY: table_vld=1. A lookup with lk_valid is registered: rd_valid=1 and rd_data=LUT[lk_addr]
//    on the next cycle. Otherwise rd_valid=0 and rd_data holds its value.
//  - Lookups in IDLE/LOAD/WRITE are dropped (rd_valid=0).
//  - load_start in any state, including mid-load: abort, word_cnt=0, table_vld=0, enter LOAD next cycle.
//    A word being written is discarded. load_start has priority over a same-cycle lookup or handshake.
//  - done and err are never asserted together. busy = state in {LOAD, WRITE}.
//  - rst mid-operation: immediate return to reset state. No done or err pulse.
// STRUCTURE
//  - lut_loader_pkg: state enum {IDLE, LOAD, WRITE, READY}; localparams DEPTH, EPW, NW;
//    clog2-based counter widths.
//  - Sub-module lut_ram_sp: DEPTH x OUT_BITS distributed RAM (rom_style/ram_style distributed),
//    1 sync write port, 1 async read port. The read is registered in the parent.
//  - Top: FSM, word/slice counters, shift register, lookup output register.
// TESTING
//  1. Reset, then load 8 words of 0xA5A5A5A5 with cfg_last on word 7 -> done at cycle 264,
//     table_vld=1; lk_addr=0 -> rd_data=1, lk_addr=1 -> 0, one cycle later.
//  2. Exhaustive: load a random table, sweep lk_addr 0..255 back-to-back -> rd_valid every cycle,
//     each rd_data matches the model; 256 results over 257 cycles.
//  3. cfg_last on word 3 -> err pulse after word 3 written, table_vld=0, lookups give rd_valid=0.
//  4. Word 7 without cfg_last -> err=1, state IDLE. A further cfg_valid is not accepted (cfg_ready=0).
//  5. load_start during WRITE of word 5 -> busy stays 1, word_cnt restarts at 0. A full reload
//     then gives done with the new table only.
//  6. Stall: cfg_valid toggling randomly in LOAD, and lk_valid with load_start in the same READY cycle
//     -> the lookup is dropped and the table loads correctly.

Source files
------------

// File: rtl/lut_loader_pkg.sv
// Shared types and sizing for the runtime-loadable neuron truth-table writer.
package lut_loader_pkg;

  localparam int unsigned IN_BITS_DEF  = 8;
  localparam int unsigned OUT_BITS_DEF = 1;
  localparam int unsigned WORD_W_DEF   = 32;

  localparam int unsigned DEPTH = 2 ** IN_BITS_DEF;
  localparam int unsigned EPW   = WORD_W_DEF / OUT_BITS_DEF;
  localparam int unsigned NW    = DEPTH / EPW;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_READY = 2'd3;

  // Counter width that stays at least one bit for degenerate counts.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lut_ram_sp.sv
// Distributed-RAM truth table: one synchronous write port, one asynchronous read port.
module lut_ram_sp
  import lut_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = IN_BITS_DEF,
  parameter int unsigned DATA_W = OUT_BITS_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  (* ram_style = "distributed" *)
  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lut_table_loader.sv
// Unpacks a packed truth-table stream into a LUT RAM and serves registered lookups.
module lut_table_loader
  import lut_loader_pkg::*;
#(
  parameter int unsigned IN_BITS  = IN_BITS_DEF,
  parameter int unsigned OUT_BITS = OUT_BITS_DEF,
  parameter int unsigned WORD_W   = WORD_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [WORD_W-1:0]   cfg_data,
  input  logic                cfg_last,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                table_vld,
  input  logic                lk_valid,
  input  logic [IN_BITS-1:0]  lk_addr,
  output logic                rd_valid,
  output logic [OUT_BITS-1:0] rd_data
);

  localparam int unsigned LUT_DEPTH = 2 ** IN_BITS;
  localparam int unsigned LUT_EPW   = WORD_W / OUT_BITS;
  localparam int unsigned LUT_NW    = LUT_DEPTH / LUT_EPW;
  localparam int unsigned WC_W      = cnt_w(LUT_NW);
  localparam int unsigned SC_W      = cnt_w(LUT_EPW);

  logic [1:0]          state, state_n;
  logic [WC_W-1:0]     word_cnt;
  logic [SC_W-1:0]     slice_cnt;
  logic [WORD_W-1:0]   shreg;
  logic                last_q;
  logic                accept, wr_en, word_inc, done_n, err_n;
  logic                last_slice, final_word, lk_serve;
  logic [IN_BITS-1:0]  wr_addr;
  logic [OUT_BITS-1:0] ram_rdata;

  assign last_slice = (slice_cnt == SC_W'(LUT_EPW - 1));
  assign final_word = (word_cnt == WC_W'(LUT_NW - 1));
  assign wr_addr    = IN_BITS'(word_cnt) * IN_BITS'(LUT_EPW) + IN_BITS'(slice_cnt);
  assign lk_serve   = (state == ST_READY) && lk_valid && !load_start;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // load_start overrides every state, including an in-flight handshake or write.
  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    wr_en    = 1'b0;
    word_inc = 1'b0;
    done_n   = 1'b0;
    err_n    = 1'b0;
    if (load_start) begin
      state_n = ST_LOAD;
    end else begin
      case (state)
        ST_IDLE:  state_n = ST_IDLE;
        ST_LOAD: begin
          if (cfg_valid) begin
            accept  = 1'b1;
            state_n = ST_WRITE;
          end
        end
        ST_WRITE: begin
          wr_en = 1'b1;
          if (last_slice) begin
            if (final_word && last_q) begin
              state_n = ST_READY;
              done_n  = 1'b1;
            end else if (!final_word && !last_q) begin
              state_n  = ST_LOAD;
              word_inc = 1'b1;
            end else begin
              state_n = ST_IDLE;
              err_n   = 1'b1;
            end
          end
        end
        ST_READY: state_n = ST_READY;
        default:  state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt  <= '0;
      slice_cnt <= '0;
      shreg     <= '0;
      last_q    <= 1'b0;
    end else if (load_start) begin
      word_cnt  <= '0;
      slice_cnt <= '0;
    end else if (accept) begin
      shreg     <= cfg_data;
      last_q    <= cfg_last;
      slice_cnt <= '0;
    end else if (wr_en) begin
      shreg     <= shreg >> OUT_BITS;
      slice_cnt <= last_slice ? '0 : slice_cnt + SC_W'(1);
      if (last_slice) word_cnt <= word_inc ? word_cnt + WC_W'(1) : '0;
    end
  end

  // Status outputs track the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      table_vld <= 1'b0;
    end else begin
      cfg_ready <= (state_n == ST_LOAD);
      busy      <= (state_n == ST_LOAD) || (state_n == ST_WRITE);
      done      <= done_n;
      err       <= err_n;
      table_vld <= (state_n == ST_READY);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= lk_serve;
      if (lk_serve) rd_data <= ram_rdata;
    end
  end

  lut_ram_sp #(
    .ADDR_W(IN_BITS),
    .DATA_W(OUT_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (shreg[OUT_BITS-1:0]),
    .raddr (lk_addr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_lut_table_loader.sv
// Randomized bench for lut_table_loader against an address-indexed truth-table model.
module tb_lut_table_loader;

  logic        clk = 1'b0;
  logic        rst, load_start, cfg_valid, cfg_last, lk_valid;
  logic [31:0] cfg_data;
  logic [7:0]  lk_addr;
  logic        cfg_ready, busy, done, err, table_vld, rd_valid;
  logic [0:0]  rd_data;

  lut_table_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .busy(busy), .done(done), .err(err), .table_vld(table_vld),
    .lk_valid(lk_valid), .lk_addr(lk_addr), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_chk = 0;
  int          n_bad = 0;
  logic [31:0] words [8];
  bit          model [256];
  bit          model_ok;
  int          hs_cyc, first_hs;
  bit          gd, ge;
  int          at;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Entry for address a lives in word a/32, bit a%32.
  task automatic build_model();
    for (int a = 0; a < 256; a++) model[a] = words[a / 32][a % 32];
    model_ok = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, input bit stall);
    int  n;
    bit  sent;
    n = 0;
    sent = 1'b0;
    cfg_data = d;
    cfg_last = l;
    while (!sent) begin
      cfg_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (cfg_valid && cfg_ready) begin
        hs_cyc = cyc;
        sent = 1'b1;
      end
      tick();
      n++;
      if (!sent && n > 300) begin
        check("handshake_timeout", 32'd0, 32'd1);
        sent = 1'b1;
      end
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic wait_end(output bit got_done, output bit got_err, output int when);
    got_done = 1'b0;
    got_err  = 1'b0;
    when     = 0;
    for (int i = 0; i < 200 && !got_done && !got_err; i++) begin
      tick();
      if (done) begin
        got_done = 1'b1;
        when = cyc;
        check("done_excl_err", 32'(err), 32'd0);
      end else if (err) begin
        got_err = 1'b1;
        when = cyc;
      end
    end
  endtask

  task automatic load_table(input bit do_start, input int n_words, input int last_idx,
                            input bit stall);
    if (do_start) pulse_start();
    for (int k = 0; k < n_words; k++) begin
      send_word(words[k], k == last_idx, stall);
      if (k == 0) first_hs = hs_cyc;
    end
    wait_end(gd, ge, at);
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 256; a++) begin
      lk_addr  = 8'(a);
      lk_valid = 1'b1;
      tick();
      check({tag, "_rdv"}, 32'(rd_valid), 32'(model_ok));
      if (model_ok) check({tag, "_rdd"}, 32'(rd_data), 32'(model[a]));
    end
    lk_valid = 1'b0;
    tick();
    check({tag, "_rdv_idle"}, 32'(rd_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; cfg_valid = 1'b0; cfg_last = 1'b0;
    cfg_data = '0; lk_valid = 1'b0; lk_addr = '0; model_ok = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_table_vld", 32'(table_vld), 32'd0);
    check("rst_rd_valid",  32'(rd_valid),  32'd0);
    check("rst_rd_data",   32'(rd_data),   32'd0);
    lk_valid = 1'b1;
    tick();
    lk_valid = 1'b0;
    check("idle_lookup_drop", 32'(rd_valid), 32'd0);

    // 1: constant pattern, timing of done
    for (int k = 0; k < 8; k++) words[k] = 32'hA5A5_A5A5;
    load_table(1'b1, 8, 7, 1'b0);
    check("t1_done", 32'(gd), 32'd1);
    check("t1_done_cycle", 32'(at - first_hs), 32'd264);
    check("t1_table_vld", 32'(table_vld), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    lk_addr = 8'd0; lk_valid = 1'b1;
    tick();
    check("t1_rdv0", 32'(rd_valid), 32'd1);
    check("t1_rdd0", 32'(rd_data), 32'd1);
    lk_addr = 8'd1;
    tick();
    check("t1_rdv1", 32'(rd_valid), 32'd1);
    check("t1_rdd1", 32'(rd_data), 32'd0);
    lk_valid = 1'b0;

    // 2: random table, exhaustive sweep
    for (int k = 0; k < 8; k++) words[k] = $urandom();
    load_table(1'b1, 8, 7, 1'b0);
    check("t2_done", 32'(gd), 32'd1);
    build_model();
    sweep("t2");

    // 3: last marked early on word 3
    for (int k = 0; k < 8; k++) words[k] = $urandom();
    load_table(1'b1, 4, 3, 1'b0);
    check("t3_err", 32'(ge), 32'd1);
    check("t3_no_done", 32'(gd), 32'd0);
    check("t3_err_cycle", 32'(at - hs_cyc), 32'd33);
    check("t3_table_vld", 32'(table_vld), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    model_ok = 1'b0;
    sweep("t3");

    // 4: last missing on word 7
    load_table(1'b1, 8, -1, 1'b0);
    check("t4_err", 32'(ge), 32'd1);
    check("t4_no_done", 32'(gd), 32'd0);
    cfg_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_cfg_ready", 32'(cfg_ready), 32'd0);
      check("t4_busy", 32'(busy), 32'd0);
    end
    cfg_valid = 1'b0;

    // 5: abort during write of word 5, then full reload
    for (int k = 0; k < 8; k++) words[k] = $urandom();
    pulse_start();
    for (int k = 0; k < 6; k++) send_word(words[k], 1'b0, 1'b0);
    repeat (10) tick();
    check("t5_in_write_busy", 32'(busy), 32'd1);
    check("t5_in_write_ready", 32'(cfg_ready), 32'd0);
    pulse_start();
    check("t5_abort_busy", 32'(busy), 32'd1);
    check("t5_abort_ready", 32'(cfg_ready), 32'd1);
    check("t5_abort_vld", 32'(table_vld), 32'd0);
    for (int k = 0; k < 8; k++) words[k] = $urandom();
    load_table(1'b0, 8, 7, 1'b0);
    check("t5_done", 32'(gd), 32'd1);
    check("t5_done_cycle", 32'(at - first_hs), 32'd264);
    build_model();
    sweep("t5");

    // 6: load_start beats a same-cycle lookup; stalled reload
    lk_addr = 8'($urandom_range(0, 255));
    lk_valid = 1'b1;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("t6_lookup_dropped", 32'(rd_valid), 32'd0);
    check("t6_vld_clear", 32'(table_vld), 32'd0);
    check("t6_busy", 32'(busy), 32'd1);
    tick();
    check("t6_load_lookup_drop", 32'(rd_valid), 32'd0);
    lk_valid = 1'b0;
    for (int k = 0; k < 8; k++) words[k] = $urandom();
    load_table(1'b0, 8, 7, 1'b1);
    check("t6_done", 32'(gd), 32'd1);
    check("t6_table_vld", 32'(table_vld), 32'd1);
    build_model();
    sweep("t6");

    // reset mid-load clears everything with no pulses
    pulse_start();
    send_word(32'hFFFF_0000, 1'b0, 1'b0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ready", 32'(cfg_ready), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    check("rst_mid_vld", 32'(table_vld), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
